desloc_multiciclo: RTL and testbench
====================================

# desloc_multiciclo

Multi-cycle shift unit for the datapath, sitting directly downstream of the shift-amount source mux. It consumes the 5-bit shift amount selected by that mux and a 32-bit operand, then performs the shift one bit position per clock cycle. It reports completion to the control unit with a `done` pulse and holds the result until the next operation starts.

## Interface
- `LARGURA`, 32: operand/result width.
- `LARG_SHAMT`, 5: shift-amount width; must satisfy 2^LARG_SHAMT = LARGURA.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset (one clock; reset is synchronous and active-low).
- `start` in 1: request a new operation; sampled on a rising edge.
- `op` in 3: operation code.
  - 001 SLL
  - 010 SRL
  - 011 SRA
  - 100 ROR
  - 101 ROL
  - 000/110/111 pass-through
- `dado_in` in LARGURA: operand, sampled with `start`.
- `shamt` in LARG_SHAMT: shift amount (output of the ShiftSrc mux), sampled with `start`.
- `resultado` out LARGURA: shifted value; registered.
- `busy` out 1: high while shifting.
- `done` out 1: one-cycle completion pulse; registered.

## Operation
- FSM with three states: OCIOSO, DESLOCANDO, CONCLUIDO. Internal registers:
  - `acc` (LARGURA), drives `resultado` directly.
  - `cont` (LARG_SHAMT).
  - `op_r` (3).
- Accepting a request:
  - `start`=1 on an edge while in OCIOSO or CONCLUIDO: `acc<=dado_in`, `op_r<=op`, `cont<=shamt`.
  - If `shamt`=0 or `op` is a pass-through code, next state is CONCLUIDO. Otherwise it is DESLOCANDO.
- DESLOCANDO, on each edge:
  - `acc` moves one position according to `op_r`, and `cont<=cont-1`.
  - SLL shifts in 0 at bit 0. SRL shifts in 0 at the MSB. SRA replicates the MSB. ROR moves bit 0 to the MSB. ROL moves the MSB to bit 0.
  - When `cont`=1 at that edge, next state is CONCLUIDO.
- CONCLUIDO lasts one cycle, with `done`=1.
  - Next state is OCIOSO, or a new operation if `start`=1 (back-to-back operations are allowed).
- `start` while in DESLOCANDO is ignored. `dado_in`, `shamt` and `op` are don't-care outside the accepting edge.
- `busy` = (state==DESLOCANDO). `done` = (state==CONCLUIDO). Both are decoded from the state register, so they are glitch-free.
- `resultado` holds its last value in OCIOSO and CONCLUIDO. During DESLOCANDO it shows the partial value, which is not valid until `done`.
- Shift amount 31 is the maximum. There is no wrap and no modulo beyond the 5-bit field.

## Timing
- Reset (`reset_n`=0 at an edge), values on the following cycle:
  - state=OCIOSO
  - `acc`=0, `cont`=0, `op_r`=000
  - `resultado`=0x00000000, `busy`=0, `done`=0
  - Reset has priority over `start`.
- Reset in any state, including mid-DESLOCANDO, aborts the operation. No `done` is issued for the aborted operation.
- Latency: with `start` sampled at the end of cycle 0 and N = effective shift amount, `done`=1 during cycle N+1.
  - N is 0 for pass-through codes and for `shamt`=0.
  - `resultado` is final from cycle N+1 onward and stays stable until the next accepted `start`.
- `busy`=1 exactly during cycles 1..N. It stays 0 for N=0.
- Back-to-back: `start` in the `done` cycle begins the next operation, so the new `busy` or `done` appears in the following cycle. The previous `resultado` is overwritten by the new `dado_in` at that edge.
- Throughput: one operation per N+1 cycles at best.

## Test plan
- Reset, then SLL:
  - Stimulus: `reset_n` low for 2 cycles, then `start` with op=001, `dado_in`=0x00000001, `shamt`=4 in cycle 0.
  - Response: `busy`=1 in cycles 1-4; `done`=1 only in cycle 5; `resultado`=0x00000010.
  - All outputs are 0 during reset.
- SRA and SRL at extremes:
  - op=011, 0x80000000, `shamt`=31 → 0xFFFFFFFF, with `done` in cycle 32.
  - op=010, same operand → 0x00000001.
- Rotations:
  - op=100, 0x00000001, `shamt`=1 → 0x80000000, `done` in cycle 2.
  - op=101, 0x80000003, `shamt`=4 → 0x00000038.
- Zero and pass-through:
  - op=001, 0xDEADBEEF, `shamt`=0 → `done` in cycle 1, `resultado`=0xDEADBEEF, `busy` never high.
  - op=111, `shamt`=9 → same behaviour as `shamt`=0.
- Ignored `start` and back-to-back:
  - While busy: SLL 0x1 by 8, with `start` re-asserted in cycle 3 (op=010, 0xFFFFFFFF). The second request is ignored; result is 0x00000100 in cycle 9.
  - Back-to-back: `start` in cycle 9 (SRL 0x100 by 8) is accepted, giving `done` in cycle 18 and result 0x00000001.
- Reset mid-operation:
  - Stimulus: SLL 0x1 by 20, with `reset_n`=0 at the cycle-6 edge.
  - Response: next cycle shows `resultado`=0, `busy`=0, `done`=0. No `done` appears later. A new `start` afterwards completes normally.

Source files
------------

// File: rtl/desloc_multiciclo.sv
// Multi-cycle shifter: shifts or rotates the operand one bit position per clock
// and pulses done when the result in resultado is final.
module desloc_multiciclo #(
    parameter int LARGURA    = 32,
    parameter int LARG_SHAMT = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [LARGURA-1:0]    dado_in,
    input  logic [LARG_SHAMT-1:0] shamt,
    output logic [LARGURA-1:0]    resultado,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_ROL = 3'b101;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        DESLOCANDO = 2'd1,
        CONCLUIDO  = 2'd2
    } estado_t;

    estado_t               state_reg, state_next;
    logic [LARGURA-1:0]    acc_reg, acc_next;
    logic [LARG_SHAMT-1:0] cont_reg, cont_next;
    logic [2:0]            op_reg, op_next;

    logic [LARGURA-1:0] sll_v, srl_v, sra_v, ror_v, rol_v;
    logic               pass;

    // Single-step versions of acc for every operation; the edge bits differ per op.
    generate
        for (genvar gi = 0; gi < LARGURA; gi++) begin : g_passo
            if (gi == 0) begin : g_lsb
                assign sll_v[gi] = 1'b0;
                assign rol_v[gi] = acc_reg[LARGURA-1];
            end else begin : g_lsb_n
                assign sll_v[gi] = acc_reg[gi-1];
                assign rol_v[gi] = acc_reg[gi-1];
            end
            if (gi == LARGURA-1) begin : g_msb
                assign srl_v[gi] = 1'b0;
                assign sra_v[gi] = acc_reg[gi];
                assign ror_v[gi] = acc_reg[0];
            end else begin : g_msb_n
                assign srl_v[gi] = acc_reg[gi+1];
                assign sra_v[gi] = acc_reg[gi+1];
                assign ror_v[gi] = acc_reg[gi+1];
            end
        end
    endgenerate

    assign pass = (op == 3'b000) || (op == 3'b110) || (op == 3'b111);

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cont_next  = cont_reg;
        op_next    = op_reg;
        case (state_reg)
            OCIOSO, CONCLUIDO: begin
                state_next = OCIOSO;
                if (start) begin
                    acc_next   = dado_in;
                    op_next    = op;
                    cont_next  = shamt;
                    state_next = (shamt == '0 || pass) ? CONCLUIDO : DESLOCANDO;
                end
            end
            DESLOCANDO: begin
                case (op_reg)
                    OP_SLL:  acc_next = sll_v;
                    OP_SRL:  acc_next = srl_v;
                    OP_SRA:  acc_next = sra_v;
                    OP_ROR:  acc_next = ror_v;
                    OP_ROL:  acc_next = rol_v;
                    default: acc_next = acc_reg;
                endcase
                cont_next = cont_reg - LARG_SHAMT'(1);
                if (cont_reg == LARG_SHAMT'(1)) begin
                    state_next = CONCLUIDO;
                end
            end
            default: state_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= OCIOSO;
            acc_reg   <= '0;
            cont_reg  <= '0;
            op_reg    <= 3'b000;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cont_reg  <= cont_next;
            op_reg    <= op_next;
        end
    end

    assign resultado = acc_reg;
    assign busy      = (state_reg == DESLOCANDO);
    assign done      = (state_reg == CONCLUIDO);

endmodule

// File: tb/tb_desloc_multiciclo.sv
// Scoreboard bench for desloc_multiciclo: each accepted request queues its
// expected result and done cycle; a negedge monitor checks done/busy/resultado.
module tb_desloc_multiciclo;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] dado_in;
    logic [4:0]  shamt;
    logic [31:0] resultado;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] res;
        int          c0;
        int          done_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    desloc_multiciclo #(.LARGURA(32), .LARG_SHAMT(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .dado_in   (dado_in),
        .shamt     (shamt),
        .resultado (resultado),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s);
        logic [31:0] r;
        case (o)
            3'b001:  r = d << s;
            3'b010:  r = d >> s;
            3'b011:  r = $signed(d) >>> s;
            3'b100:  r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
            3'b101:  r = (s == 0) ? d : ((d << s) | (d >> (32 - s)));
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int eff_n(input logic [2:0] o, input logic [4:0] s);
        if (o == 3'b000 || o == 3'b110 || o == 3'b111) return 0;
        return int'(s);
    endfunction

    // Monitor: done/busy timing against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            logic exp_done;
            logic exp_busy;
            exp_t e;
            exp_done = (q.size() > 0) && (cyc == q[0].done_cyc);
            chk("done", {31'b0, done}, {31'b0, exp_done});
            if (exp_done) begin
                e = q.pop_front();
                chk("resultado", resultado, e.res);
                $display("op done at cycle %0d: resultado=%h expected=%h", cyc, resultado, e.res);
            end
            exp_busy = (q.size() > 0) && (cyc > q[0].c0) && (cyc < q[0].done_cyc);
            chk("busy", {31'b0, busy}, {31'b0, exp_busy});
        end
    end

    // Drives one request for the cycle ending at the next edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s, input bit accept);
        exp_t e;
        start   = 1'b1;
        op      = o;
        dado_in = d;
        shamt   = s;
        if (accept) begin
            e.res      = model(o, d, s);
            e.c0       = cyc;
            e.done_cyc = cyc + eff_n(o, s) + 1;
            q.push_back(e);
        end
        @(posedge clk); #1;
        start   = 1'b0;
        op      = 3'($urandom);
        dado_in = $urandom;
        shamt   = 5'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = budget;
        while (q.size() != 0 && b > 0) begin
            @(posedge clk); #1;
            b--;
        end
        chk("timeout", q.size(), 0);
        q.delete();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        dado_in = '0;
        shamt   = '0;
        step(2);
        chk("rst_resultado", resultado, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        reset_n = 1'b1;

        issue(3'b001, 32'h0000_0001, 5'd4, 1'b1);
        wait_idle(20);
        chk("sll_plan", resultado, 32'h0000_0010);

        issue(3'b011, 32'h8000_0000, 5'd31, 1'b1);
        wait_idle(50);
        chk("sra_plan", resultado, 32'hFFFF_FFFF);
        issue(3'b010, 32'h8000_0000, 5'd31, 1'b1);
        wait_idle(50);
        chk("srl_plan", resultado, 32'h0000_0001);

        issue(3'b100, 32'h0000_0001, 5'd1, 1'b1);
        wait_idle(10);
        chk("ror_plan", resultado, 32'h8000_0000);
        issue(3'b101, 32'h8000_0003, 5'd4, 1'b1);
        wait_idle(10);
        chk("rol_plan", resultado, 32'h0000_0038);

        issue(3'b001, 32'hDEAD_BEEF, 5'd0, 1'b1);
        wait_idle(10);
        chk("zero_plan", resultado, 32'hDEAD_BEEF);
        issue(3'b111, 32'h1234_5678, 5'd9, 1'b1);
        wait_idle(10);
        chk("pass_plan", resultado, 32'h1234_5678);
        step(3);
        chk("hold", resultado, 32'h1234_5678);

        // Ignored start while busy, then back-to-back request in the done cycle.
        issue(3'b001, 32'h0000_0001, 5'd8, 1'b1);
        step(2);
        issue(3'b010, 32'hFFFF_FFFF, 5'd3, 1'b0);
        step(5);
        chk("b2b_first", resultado, 32'h0000_0100);
        issue(3'b010, 32'h0000_0100, 5'd8, 1'b1);
        wait_idle(20);
        chk("b2b_second", resultado, 32'h0000_0001);

        // Reset in the middle of a long shift.
        issue(3'b001, 32'h0000_0001, 5'd20, 1'b1);
        step(5);
        reset_n = 1'b0;
        q.delete();
        step(1);
        reset_n = 1'b1;
        chk("abort_resultado", resultado, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        step(25);
        issue(3'b101, 32'hF000_000F, 5'd8, 1'b1);
        wait_idle(20);
        chk("after_abort", resultado, 32'h0000_0FF0);

        for (int i = 0; i < 12; i++) begin
            issue(3'($urandom_range(0, 7)), $urandom, 5'($urandom), 1'b1);
            wait_idle(40);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
